// File: rtl/ps2_keypad_pkg.sv
// Shared constants, state encodings and scancode helpers for the PS/2 CHIP-8 keypad.
// Set-2 scancodes map onto the 4x4 CHIP-8 hex keypad (1234/QWER/ASDF/ZXCV).
package ps2_keypad_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORM    = 2'd0,
        DEC_BRK     = 2'd1,
        DEC_EXT     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] key;
    } key_map_t;

    function automatic key_map_t map_scancode(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        case (code)
            8'h16:   m.key = 4'h1;
            8'h1E:   m.key = 4'h2;
            8'h26:   m.key = 4'h3;
            8'h25:   m.key = 4'hC;
            8'h15:   m.key = 4'h4;
            8'h1D:   m.key = 4'h5;
            8'h24:   m.key = 4'h6;
            8'h2D:   m.key = 4'hD;
            8'h1C:   m.key = 4'h7;
            8'h1B:   m.key = 4'h8;
            8'h23:   m.key = 4'h9;
            8'h2B:   m.key = 4'hE;
            8'h1A:   m.key = 4'hA;
            8'h22:   m.key = 4'h0;
            8'h21:   m.key = 4'hB;
            8'h2A:   m.key = 4'hF;
            default: begin
                m.hit = 1'b0;
                m.key = 4'h0;
            end
        endcase
        return m;
    endfunction

    // Nine data+parity bits must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keypad_rx.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter and
// 11-bit frame FSM producing one-cycle byte-valid / frame-error strobes.
module ps2_rx
    import ps2_keypad_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    logic           r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
    logic           r_filt_clk, r_filt_prev;
    logic [FCW-1:0] r_filt_cnt;
    logic           w_sample;

    rx_state_t      r_state, w_state_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [2:0]     r_bitcnt, w_bitcnt_nxt;
    logic           r_par, w_par_nxt;
    logic [TCW-1:0] r_tmo, w_tmo_nxt;
    logic           w_byte_ok, w_err;
    logic [7:0]     r_byte;
    logic           r_byte_valid, r_frame_err;

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN stable cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (r_clk_sync != r_filt_clk) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_filt_clk <= r_clk_sync;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_sample = r_filt_prev & ~r_filt_clk;

    // Frame FSM next-state, shift and timeout logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_tmo_nxt    = r_tmo;
        w_byte_ok    = 1'b0;
        w_err        = 1'b0;

        if (r_state == RX_IDLE || w_sample) begin
            w_tmo_nxt = '0;
        end else begin
            w_tmo_nxt = r_tmo + 1'b1;
        end

        case (r_state)
            RX_IDLE: begin
                if (w_sample && !r_dat_sync) begin
                    w_state_nxt  = RX_DATA;
                    w_bitcnt_nxt = 3'd0;
                end else begin
                    w_state_nxt  = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (w_sample) begin
                    w_shift_nxt  = {r_dat_sync, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = RX_PARITY;
                    end else begin
                        w_state_nxt = RX_DATA;
                    end
                end else begin
                    w_state_nxt = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (w_sample) begin
                    w_par_nxt   = r_dat_sync;
                    w_state_nxt = RX_STOP;
                end else begin
                    w_state_nxt = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (w_sample) begin
                    w_state_nxt = RX_IDLE;
                    if (r_dat_sync && odd_parity_ok(r_shift, r_par)) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_state_nxt = RX_STOP;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase

        // A stalled partial frame is abandoned and reported.
        if (r_state != RX_IDLE && !w_sample && r_tmo == TMO_LAST) begin
            w_state_nxt = RX_IDLE;
            w_tmo_nxt   = '0;
            w_err       = 1'b1;
        end else begin
            w_err = w_err;
        end
    end

    // Frame FSM state and registered strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= RX_IDLE;
            r_shift      <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_par        <= 1'b0;
            r_tmo        <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_par        <= w_par_nxt;
            r_tmo        <= w_tmo_nxt;
            r_byte_valid <= w_byte_ok;
            r_frame_err  <= w_err;
            if (w_byte_ok) begin
                r_byte <= r_shift;
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to CHIP-8 keypad bridge: frame receiver plus a make/break
// scancode decoder that maintains the 16-key held state.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLK_25MHZ,
    input  logic        RESET_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KEYS,
    output logic        KEY_EVENT,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_PRESSED,
    output logic        FRAME_ERR
);

    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        w_frame_err;
    key_map_t    w_map;

    dec_state_t  r_dec, w_dec_nxt;
    logic [15:0] r_keys, w_keys_nxt;
    logic        r_event, w_event;
    logic [3:0]  r_code, w_code_nxt;
    logic        r_pressed, w_pressed_nxt;
    logic        r_frame_err;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk        (CLK_25MHZ),
        .i_rst_n      (RESET_N),
        .i_ps2_clk    (PS2_CLK),
        .i_ps2_data   (PS2_DATA),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_map = map_scancode(w_byte);

    // Decoder next-state: prefix tracking and key set/clear with change detection.
    always_comb begin
        w_dec_nxt     = r_dec;
        w_keys_nxt    = r_keys;
        w_event       = 1'b0;
        w_code_nxt    = r_code;
        w_pressed_nxt = r_pressed;

        if (w_frame_err) begin
            w_dec_nxt = DEC_NORM;
        end else if (w_byte_valid) begin
            case (r_dec)
                DEC_NORM: begin
                    if (w_byte == SC_BRK) begin
                        w_dec_nxt = DEC_BRK;
                    end else if (w_byte == SC_EXT) begin
                        w_dec_nxt = DEC_EXT;
                    end else begin
                        w_dec_nxt = DEC_NORM;
                        // Typematic repeats of a held key are silent.
                        if (w_map.hit && !r_keys[w_map.key]) begin
                            w_keys_nxt[w_map.key] = 1'b1;
                            w_event               = 1'b1;
                            w_code_nxt            = w_map.key;
                            w_pressed_nxt         = 1'b1;
                        end else begin
                            w_event = 1'b0;
                        end
                    end
                end
                DEC_BRK: begin
                    w_dec_nxt = DEC_NORM;
                    if (w_map.hit && r_keys[w_map.key]) begin
                        w_keys_nxt[w_map.key] = 1'b0;
                        w_event               = 1'b1;
                        w_code_nxt            = w_map.key;
                        w_pressed_nxt         = 1'b0;
                    end else begin
                        w_event = 1'b0;
                    end
                end
                DEC_EXT: begin
                    if (w_byte == SC_BRK) begin
                        w_dec_nxt = DEC_EXT_BRK;
                    end else begin
                        w_dec_nxt = DEC_NORM;
                    end
                end
                DEC_EXT_BRK: begin
                    w_dec_nxt = DEC_NORM;
                end
                default: begin
                    w_dec_nxt = DEC_NORM;
                end
            endcase
        end else begin
            w_dec_nxt = r_dec;
        end
    end

    // Decoder state and registered keypad outputs.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dec       <= DEC_NORM;
            r_keys      <= 16'h0000;
            r_event     <= 1'b0;
            r_code      <= 4'h0;
            r_pressed   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dec       <= w_dec_nxt;
            r_keys      <= w_keys_nxt;
            r_event     <= w_event;
            r_code      <= w_code_nxt;
            r_pressed   <= w_pressed_nxt;
            r_frame_err <= w_frame_err;
        end
    end

    assign KEYS        = r_keys;
    assign KEY_EVENT   = r_event;
    assign KEY_CODE    = r_code;
    assign KEY_PRESSED = r_pressed;
    assign FRAME_ERR   = r_frame_err;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: bit-banged PS/2 frames with hand-computed
// expected keypad state, event and error counts.
module tb_ps2_keypad;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keys;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    logic [3:0] last_code = 4'h0;
    logic       last_pressed = 1'b0;
    int ev_base;
    int err_base;

    ps2_keypad dut (
        .CLK_25MHZ   (clk),
        .RESET_N     (rst_n),
        .PS2_CLK     (ps2_clk),
        .PS2_DATA    (ps2_data),
        .KEYS        (keys),
        .KEY_EVENT   (key_event),
        .KEY_CODE    (key_code),
        .KEY_PRESSED (key_pressed),
        .FRAME_ERR   (frame_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) begin
        if (key_event) begin
            ev_cnt       <= ev_cnt + 1;
            last_code    <= key_code;
            last_pressed <= key_pressed;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // nbits < 11 sends a truncated frame; glitch adds a 3-cycle low pulse mid high phase.
    task automatic send_frame(input logic [7:0] data, input logic par_good,
                              input logic stop, input int nbits, input logic glitch);
        logic [10:0] bits;
        logic        par;
        par  = par_good ? ~(^data) : (^data);
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cycles(15);
            if (glitch) begin
                ps2_clk = 1'b0;
                wait_cycles(3);
                ps2_clk = 1'b1;
                wait_cycles(12);
            end else begin
                wait_cycles(15);
            end
            ps2_clk = 1'b0;
            wait_cycles(20);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cycles(40);
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, 1'b1, 11, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        check("rst_keys", keys, 16'h0000);
        check("rst_event", {15'd0, key_event}, 16'h0000);
        check("rst_code", {12'd0, key_code}, 16'h0000);
        check("rst_pressed", {15'd0, key_pressed}, 16'h0000);
        check("rst_frame_err", {15'd0, frame_err}, 16'h0000);
        rst_n = 1'b1;
        wait_cycles(20);
        check("idle_keys", keys, 16'h0000);

        // Make 0x1C -> key 7 down.
        ev_base = ev_cnt;
        send_byte(8'h1C);
        check("make7_keys", keys, 16'h0080);
        check("make7_events", 16'(ev_cnt - ev_base), 16'd1);
        check("make7_code", {12'd0, last_code}, 16'h0007);
        check("make7_pressed", {15'd0, last_pressed}, 16'h0001);

        // F0 alone is silent; F0 1C releases key 7.
        ev_base = ev_cnt;
        send_byte(8'hF0);
        check("brk_prefix_events", 16'(ev_cnt - ev_base), 16'd0);
        check("brk_prefix_keys", keys, 16'h0080);
        send_byte(8'h1C);
        check("brk7_keys", keys, 16'h0000);
        check("brk7_events", 16'(ev_cnt - ev_base), 16'd1);
        check("brk7_code", {12'd0, last_code}, 16'h0007);
        check("brk7_pressed", {15'd0, last_pressed}, 16'h0000);

        // Bad parity 0x16 -> error, no change; good 0x16 -> key 1.
        ev_base  = ev_cnt;
        err_base = err_cnt;
        send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
        check("badpar_err", 16'(err_cnt - err_base), 16'd1);
        check("badpar_keys", keys, 16'h0000);
        check("badpar_events", 16'(ev_cnt - ev_base), 16'd0);
        send_byte(8'h16);
        check("make1_keys", keys, 16'h0002);
        check("make1_err", 16'(err_cnt - err_base), 16'd1);

        // Bad stop bit -> error, no byte.
        err_base = err_cnt;
        send_frame(8'h1A, 1'b1, 1'b0, 11, 1'b0);
        check("badstop_err", 16'(err_cnt - err_base), 16'd1);
        check("badstop_keys", keys, 16'h0002);

        // Release key 1, then extended sequences leave KEYS alone.
        send_byte(8'hF0);
        send_byte(8'h16);
        check("brk1_keys", keys, 16'h0000);
        ev_base = ev_cnt;
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("ext_events", 16'(ev_cnt - ev_base), 16'd0);
        check("ext_keys", keys, 16'h0000);
        send_byte(8'h1C);
        check("ext_then_norm_keys", keys, 16'h0080);
        check("ext_then_norm_events", 16'(ev_cnt - ev_base), 16'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("clear7_keys", keys, 16'h0000);

        // Frame error while in BRK returns decoder to NORM: 1A is then a make.
        ev_base = ev_cnt;
        send_byte(8'hF0);
        send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
        send_byte(8'h1A);
        check("err_to_norm_keys", keys, 16'h0400);
        check("err_to_norm_pressed", {15'd0, last_pressed}, 16'h0001);
        send_byte(8'hF0);
        send_byte(8'h1A);
        check("clearA_keys", keys, 16'h0000);

        // Five clock edges then silence -> one timeout error.
        err_base = err_cnt;
        send_frame(8'h22, 1'b1, 1'b1, 5, 1'b0);
        check("pre_timeout_err", 16'(err_cnt - err_base), 16'd0);
        wait_cycles(50100);
        check("timeout_err", 16'(err_cnt - err_base), 16'd1);
        check("timeout_keys", keys, 16'h0000);
        send_byte(8'h22);
        check("make0_keys", keys, 16'h0001);

        // Glitchy clock, repeated 0x2A make -> one event.
        ev_base  = ev_cnt;
        err_base = err_cnt;
        send_frame(8'h2A, 1'b1, 1'b1, 11, 1'b1);
        send_frame(8'h2A, 1'b1, 1'b1, 11, 1'b1);
        check("glitch_keys", keys, 16'h8001);
        check("glitch_events", 16'(ev_cnt - ev_base), 16'd1);
        check("glitch_code", {12'd0, last_code}, 16'h000F);
        check("glitch_err", 16'(err_cnt - err_base), 16'd0);

        // Reset mid-frame discards the frame silently.
        err_base = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 3, 1'b0);
        rst_n = 1'b0;
        wait_cycles(5);
        check("midrst_keys", keys, 16'h0000);
        rst_n = 1'b1;
        wait_cycles(50100);
        check("midrst_err", 16'(err_cnt - err_base), 16'd0);
        send_byte(8'h1C);
        check("post_rst_keys", keys, 16'h0080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keypad.md
PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive stable cycles required before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: idle cycles (2 ms at 25 MHz) after which a partial frame is abandoned.
REQ-003 CLK_25MHZ  input  1  sole clock; all logic on its rising edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 PS2_CLK  input  1  raw keyboard clock pin, asynchronous to CLK_25MHZ.
REQ-006 PS2_DATA  input  1  raw keyboard data pin, asynchronous to CLK_25MHZ.
REQ-007 KEYS  output  16  held state of CHIP-8 keys 0x0..0xF; bit n = key n down.
REQ-008 KEY_EVENT  output  1  one-cycle strobe on any KEYS bit change.
REQ-009 KEY_CODE  output  4  CHIP-8 key index of the last event; valid while KEY_EVENT=1.
REQ-010 KEY_PRESSED  output  1  1 = make, 0 = break for the last event; valid while KEY_EVENT=1.
REQ-011 FRAME_ERR  output  1  one-cycle strobe on parity, stop-bit or timeout error.

Function
REQ-012 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer before use.
REQ-013 The filtered clock SHALL take a new level only after the synchronized clock has held that level for FILTER_LEN consecutive cycles.
REQ-014 A filtered 1->0 transition SHALL produce a one-cycle sample strobe; data SHALL be sampled from synchronized PS2_DATA in that cycle.
REQ-015 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on sample with data=0, go to DATA; on sample with data=1, stay in IDLE with no error.
REQ-017 DATA: shift in 8 bits, LSB first, then go to PARITY.
REQ-018 PARITY: capture the bit, then go to STOP; the 9 data+parity bits SHALL have odd parity.
REQ-019 STOP: on sample, go to IDLE; if stop=1 and parity is good, assert byte-valid for one cycle in the next cycle; otherwise pulse FRAME_ERR and emit no byte.
REQ-020 In any non-IDLE state, TIMEOUT_CYCLES cycles with no sample strobe SHALL return the FSM to IDLE and pulse FRAME_ERR; the counter SHALL clear on every strobe.
REQ-021 Decoder FSM states: NORM, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0).
REQ-022 0xF0 in NORM -> BRK; 0xE0 in NORM -> EXT; 0xF0 in EXT -> EXT_BRK.
REQ-023 Any other byte in EXT or EXT_BRK SHALL be discarded and return the FSM to NORM; extended keys never affect KEYS.
REQ-024 In NORM or BRK, a mapped byte SHALL set (NORM) or clear (BRK) its KEYS bit, then return to NORM.
REQ-025 In NORM or BRK, an unmapped byte SHALL be ignored and return the FSM to NORM.
REQ-026 Set-2 mapping: 16->1, 1E->2, 26->3, 25->C, 15->4, 1D->5, 24->6, 2D->D, 1C->7, 1B->8, 23->9, 2B->E, 1A->A, 22->0, 21->B, 2A->F.
REQ-027 KEYS SHALL update, and KEY_EVENT/KEY_CODE/KEY_PRESSED SHALL be driven, in the cycle after byte-valid.
REQ-028 KEY_EVENT SHALL stay 0 when the bit is already in the requested state, e.g. typematic repeat of a held make code.
REQ-029 A FRAME_ERR SHALL return the decoder FSM to NORM; KEYS SHALL be unchanged.

Reset
REQ-030 While RESET_N=0: KEYS=0, KEY_EVENT=0, KEY_CODE=0, KEY_PRESSED=0, FRAME_ERR=0.
REQ-031 While RESET_N=0: both FSMs in IDLE/NORM; filter and timeout counters cleared; filtered clock=1; synchronizers=1.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no FRAME_ERR pulse.

Structure
REQ-033 Package ps2_keypad_pkg SHALL hold the prefix constants (0xE0, 0xF0), the scancode-to-key mapping function, and both FSM state enums.
REQ-034 Synchronizer, filter and frame receiver SHALL form sub-module ps2_rx, with outputs byte[7:0], byte_valid and frame_err; the decoder SHALL be top-level logic.

Verification
REQ-035 Frame 0x1C, good parity -> KEYS=0x0080, KEY_EVENT with KEY_CODE=7, KEY_PRESSED=1.
REQ-036 Then F0 1C -> KEYS=0x0000, KEY_EVENT with KEY_CODE=7, KEY_PRESSED=0; F0 alone gives no event.
REQ-037 Frame 0x16 with bad parity -> FRAME_ERR pulse, KEYS unchanged; a following good 0x16 -> KEYS bit 1 set.
REQ-038 E0 1C, then E0 F0 1C -> no KEY_EVENT, KEYS=0; FSM ends in NORM.
REQ-039 Five PS2_CLK edges then silence for 50000 cycles -> one FRAME_ERR; a subsequent clean 0x22 -> KEYS bit 0 set.
REQ-040 PS2_CLK glitches of 3 cycles mid-bit -> received byte unaffected; repeated 0x2A make -> exactly one KEY_EVENT.
